// File: rtl/config_bus_master_pkg.sv
// Shared definitions for the configuration bus initiator.
//   OP_*       : host command opcodes
//   state_t    : transaction sequencer states
//   LAT_CNT_W  : width of the read-latency cycle counter
package config_bus_master_pkg;

  localparam int unsigned LAT_CNT_W = 4;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_WVERIFY = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/config_bus_master.sv
// Configuration bus initiator: accepts one host command at a time over a
// valid/ready channel, runs a single write, read or write-then-readback
// transaction on a core's config port and returns a response.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/ready/op/addr/data : host command channel
//   rsp_valid/ready/data/error   : host response channel
//   config_config_addr/data    : bus address and write data (held per command)
//   config_read/config_write   : bus strobes
//   read_config_data           : slave read data
module config_bus_master
  import config_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] config_config_addr,
  output logic [DATA_WIDTH-1:0] config_config_data,
  output logic                  config_read,
  output logic                  config_write,
  input  logic [DATA_WIDTH-1:0] read_config_data
);

  // Index of the final read-strobe cycle (counter runs 0..READ_LATENCY)
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LATENCY);

  state_t                r_state;
  logic [1:0]            r_op;
  logic [LAT_CNT_W-1:0]  r_cnt;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_error;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_read;
  logic                  r_write;
  logic                  w_accept;

  assign w_accept = cmd_valid && r_cmd_ready;

  // Sequencer: every output is a register updated here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= OP_WRITE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_op        <= cmd_op;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_data;
            r_cnt       <= '0;
            case (cmd_op)
              OP_WRITE, OP_WVERIFY: begin
                r_write <= 1'b1;
                r_state <= WR;
              end
              OP_READ: begin
                r_read  <= 1'b1;
                r_state <= RD;
              end
              default: begin
                // Reserved op: answer with an error, never touch the bus
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_error <= 1'b1;
                r_state     <= RESP;
              end
            endcase
          end
        end
        WR: begin
          r_write <= 1'b0;
          if (r_op == OP_WVERIFY) begin
            r_read  <= 1'b1;
            r_state <= RD;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_state     <= RESP;
          end
        end
        RD: begin
          if (r_cnt == LAT_LAST) begin
            // Slave data is valid at the edge closing the last strobe cycle
            r_read      <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= read_config_data;
            r_rsp_error <= (r_op == OP_WVERIFY) && (read_config_data != r_wdata);
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + LAT_CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready          = r_cmd_ready;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_data           = r_rsp_data;
  assign rsp_error          = r_rsp_error;
  assign config_config_addr = r_addr;
  assign config_config_data = r_wdata;
  assign config_read        = r_read;
  assign config_write       = r_write;

endmodule

// File: tb/tb_config_bus_master.sv
// Bench for config_bus_master: two instances (read latency 0 and 3), each
// with a two-register slave core, a cycle-schedule reference model and a
// per-cycle compare process, plus directed literal checks.
module tb_config_bus_master;

  localparam int DEPTH = 16384;
  localparam int LATS [2] = '{0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        cv   [2];
  logic        crdy [2];
  logic [1:0]  cop  [2];
  logic [7:0]  cad  [2];
  logic [31:0] cdt  [2];
  logic        rv   [2];
  logic        rr   [2];
  logic [31:0] rd_o [2];
  logic        re   [2];
  logic [7:0]  ba   [2];
  logic [31:0] bd   [2];
  logic        brd  [2];
  logic        bwr  [2];
  logic [31:0] srd  [2];

  config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .cmd_valid(cv[0]), .cmd_ready(crdy[0]), .cmd_op(cop[0]),
    .cmd_addr(cad[0]), .cmd_data(cdt[0]), .rsp_valid(rv[0]), .rsp_ready(rr[0]),
    .rsp_data(rd_o[0]), .rsp_error(re[0]), .config_config_addr(ba[0]),
    .config_config_data(bd[0]), .config_read(brd[0]), .config_write(bwr[0]),
    .read_config_data(srd[0]));

  config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(rst[1]), .cmd_valid(cv[1]), .cmd_ready(crdy[1]), .cmd_op(cop[1]),
    .cmd_addr(cad[1]), .cmd_data(cdt[1]), .rsp_valid(rv[1]), .rsp_ready(rr[1]),
    .rsp_data(rd_o[1]), .rsp_error(re[1]), .config_config_addr(ba[1]),
    .config_config_data(bd[1]), .config_read(brd[1]), .config_write(bwr[1]),
    .read_config_data(srd[1]));

  // Slave cores: registers 0 and 1; data valid only on the L-th read cycle
  logic [31:0] smem [2][2];
  int          scnt [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        smem[d][0] <= '0;
        smem[d][1] <= '0;
      end else if (bwr[d] && ba[d] < 8'd2) begin
        smem[d][ba[d][0]] <= bd[d];
      end
      scnt[d] <= brd[d] ? scnt[d] + 1 : 0;
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      srd[d] = '0;
      if (brd[d]) begin
        if (scnt[d] == LATS[d]) srd[d] = (ba[d] < 8'd2) ? smem[d][ba[d][0]] : 32'h0;
        else                    srd[d] = 32'hBAD0_0000 | 32'(scnt[d]);
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  // Reference model: on each accepted command, schedule strobe cycles and
  // the response start cycle from the latency rules
  bit          exp_wr  [2][DEPTH];
  bit          exp_rd  [2][DEPTH];
  logic [7:0]  m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_mem   [2][2];
  bit          m_busy  [2];
  bit          m_pend  [2];
  int          m_start [2];
  int          m_rdyfrom [2];
  int          m_rstchk  [2];
  logic [31:0] m_rdata [2];
  bit          m_rerr  [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_busy[d]    <= 1'b0;
        m_pend[d]    <= 1'b0;
        m_rdyfrom[d] <= cyc + 2;
        m_rstchk[d]  <= cyc + 1;
        m_mem[d][0]  <= '0;
        m_mem[d][1]  <= '0;
        for (int k = 1; k <= 24; k++) begin
          exp_wr[d][cyc+k] <= 1'b0;
          exp_rd[d][cyc+k] <= 1'b0;
        end
      end else if (m_pend[d] && cyc >= m_start[d] && rr[d]) begin
        m_pend[d]    <= 1'b0;
        m_busy[d]    <= 1'b0;
        m_rdyfrom[d] <= cyc + 1;
      end else if (!m_busy[d] && cyc >= m_rdyfrom[d] && cv[d]) begin
        m_busy[d]  <= 1'b1;
        m_pend[d]  <= 1'b1;
        m_addr[d]  <= cad[d];
        m_wdata[d] <= cdt[d];
        case (cop[d])
          2'd0: begin
            exp_wr[d][cyc+1] <= 1'b1;
            m_start[d] <= cyc + 2;
            m_rdata[d] <= '0;
            m_rerr[d]  <= 1'b0;
            if (cad[d] < 8'd2) m_mem[d][cad[d][0]] <= cdt[d];
          end
          2'd1: begin
            for (int k = 0; k <= LATS[d]; k++) exp_rd[d][cyc+1+k] <= 1'b1;
            m_start[d] <= cyc + 2 + LATS[d];
            m_rdata[d] <= (cad[d] < 8'd2) ? m_mem[d][cad[d][0]] : 32'h0;
            m_rerr[d]  <= 1'b0;
          end
          2'd2: begin
            exp_wr[d][cyc+1] <= 1'b1;
            for (int k = 0; k <= LATS[d]; k++) exp_rd[d][cyc+2+k] <= 1'b1;
            m_start[d] <= cyc + 3 + LATS[d];
            m_rdata[d] <= (cad[d] < 8'd2) ? cdt[d] : 32'h0;
            m_rerr[d]  <= (cad[d] >= 8'd2) && (cdt[d] != 32'h0);
            if (cad[d] < 8'd2) m_mem[d][cad[d][0]] <= cdt[d];
          end
          default: begin
            m_start[d] <= cyc + 1;
            m_rdata[d] <= '0;
            m_rerr[d]  <= 1'b1;
          end
        endcase
      end
    end
    cyc <= cyc + 1;
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("cmd_ready", d, 32'(crdy[d]), 32'(!m_busy[d] && cyc >= m_rdyfrom[d]));
        chk("config_write", d, 32'(bwr[d]), 32'(exp_wr[d][cyc]));
        chk("config_read", d, 32'(brd[d]), 32'(exp_rd[d][cyc]));
        if (exp_wr[d][cyc] || exp_rd[d][cyc]) chk("bus_addr", d, 32'(ba[d]), 32'(m_addr[d]));
        if (exp_wr[d][cyc]) chk("bus_wdata", d, bd[d], m_wdata[d]);
        chk("rsp_valid", d, 32'(rv[d]), 32'(m_pend[d] && cyc >= m_start[d]));
        if (m_pend[d] && cyc >= m_start[d]) begin
          chk("rsp_data", d, rd_o[d], m_rdata[d]);
          chk("rsp_error", d, 32'(re[d]), 32'(m_rerr[d]));
        end
        if (cyc == m_rstchk[d]) begin
          chk("reset_addr", d, 32'(ba[d]), 32'h0);
          chk("reset_wdata", d, bd[d], 32'h0);
          chk("reset_rsp_data", d, rd_o[d], 32'h0);
          chk("reset_rsp_error", d, 32'(re[d]), 32'h0);
        end
      end
    end
  end

  int wcnt [2];
  int rcnt [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      wcnt[d] <= wcnt[d] + 32'(bwr[d]);
      rcnt[d] <= rcnt[d] + 32'(brd[d]);
    end
  end

  // One full command/response exchange; reports latency and strobe counts
  task automatic do_cmd(input int d, input logic [1:0] op, input logic [7:0] a,
                        input logic [31:0] dt, input int hold,
                        output logic [31:0] rdat, output logic rerr,
                        output int lat, output int nw, output int nr);
    int t0, n, w0, r0, h;
    w0 = wcnt[d];
    r0 = rcnt[d];
    cv[d] = 1'b1; cop[d] = op; cad[d] = a; cdt[d] = dt; rr[d] = 1'b0;
    n = 0;
    while (!crdy[d] && n < 40) begin @(posedge clk); #1; n++; end
    chk("accept_timeout", d, 32'(crdy[d]), 32'h1);
    t0 = cyc;
    @(posedge clk); #1;
    cv[d] = 1'b0; cdt[d] = $urandom; cad[d] = 8'($urandom);
    n = 0;
    while (!rv[d] && n < 40) begin @(posedge clk); #1; n++; end
    chk("rsp_timeout", d, 32'(rv[d]), 32'h1);
    lat = cyc - t0;
    h = hold;
    while (h > 0) begin @(posedge clk); #1; h--; end
    rdat = rd_o[d];
    rerr = re[d];
    rr[d] = 1'b1;
    @(posedge clk); #1;
    rr[d] = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    nw = wcnt[d] - w0;
    nr = rcnt[d] - r0;
  endtask

  initial begin
    logic [31:0] rdat;
    logic        rerr;
    int          lat, nw, nr, n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cv[d] = 1'b0; cop[d] = '0; cad[d] = '0; cdt[d] = '0; rr[d] = 1'b0;
      wcnt[d] = 0; rcnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_cmd_ready", 0, 32'(crdy[0]), 32'h0);
    chk("reset_rsp_valid", 0, 32'(rv[0]), 32'h0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed: latency-0 instance
    do_cmd(0, 2'd0, 8'h00, 32'hDEADBEEF, 0, rdat, rerr, lat, nw, nr);
    chk("wr_latency", 0, 32'(lat), 32'd2);
    chk("wr_strobes", 0, 32'(nw), 32'd1);
    chk("wr_no_read", 0, 32'(nr), 32'd0);
    chk("wr_rsp_data", 0, rdat, 32'h0);
    chk("wr_rsp_error", 0, 32'(rerr), 32'h0);
    do_cmd(0, 2'd1, 8'h00, 32'h0, 0, rdat, rerr, lat, nw, nr);
    chk("rd_latency", 0, 32'(lat), 32'd2);
    chk("rd_strobes", 0, 32'(nr), 32'd1);
    chk("rd_rsp_data", 0, rdat, 32'hDEADBEEF);
    chk("rd_rsp_error", 0, 32'(rerr), 32'h0);
    do_cmd(0, 2'd1, 8'h05, 32'h0, 0, rdat, rerr, lat, nw, nr);
    chk("rd5_rsp_data", 0, rdat, 32'h0);
    do_cmd(0, 2'd2, 8'h01, 32'h12345678, 0, rdat, rerr, lat, nw, nr);
    chk("wv_latency", 0, 32'(lat), 32'd3);
    chk("wv_strobes", 0, 32'(nw + nr), 32'd2);
    chk("wv_rsp_data", 0, rdat, 32'h12345678);
    chk("wv_rsp_error", 0, 32'(rerr), 32'h0);
    do_cmd(0, 2'd2, 8'h07, 32'hA5A5A5A5, 0, rdat, rerr, lat, nw, nr);
    chk("wv7_rsp_data", 0, rdat, 32'h0);
    chk("wv7_rsp_error", 0, 32'(rerr), 32'h1);
    do_cmd(0, 2'd3, 8'h01, 32'hFFFFFFFF, 5, rdat, rerr, lat, nw, nr);
    chk("rsvd_latency", 0, 32'(lat), 32'd1);
    chk("rsvd_strobes", 0, 32'(nw + nr), 32'd0);
    chk("rsvd_rsp_data", 0, rdat, 32'h0);
    chk("rsvd_rsp_error", 0, 32'(rerr), 32'h1);

    // Directed: latency-3 instance
    do_cmd(1, 2'd0, 8'h00, 32'hCAFEF00D, 0, rdat, rerr, lat, nw, nr);
    do_cmd(1, 2'd1, 8'h00, 32'h0, 0, rdat, rerr, lat, nw, nr);
    chk("l3_rd_latency", 1, 32'(lat), 32'd5);
    chk("l3_rd_strobes", 1, 32'(nr), 32'd4);
    chk("l3_rd_rsp_data", 1, rdat, 32'hCAFEF00D);
    do_cmd(1, 2'd2, 8'h01, 32'h0BADF00D, 1, rdat, rerr, lat, nw, nr);
    chk("l3_wv_latency", 1, 32'(lat), 32'd6);
    chk("l3_wv_rsp_data", 1, rdat, 32'h0BADF00D);

    // Reset during the read phase aborts the transaction
    cv[1] = 1'b1; cop[1] = 2'd1; cad[1] = 8'h01;
    n = 0;
    while (!crdy[1] && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cv[1] = 1'b0;
    n = 0;
    while (!brd[1] && n < 20) begin @(posedge clk); #1; n++; end
    chk("abort_read_seen", 1, 32'(brd[1]), 32'h1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("abort_read_low", 1, 32'(brd[1]), 32'h0);
    chk("abort_ready_low", 1, 32'(crdy[1]), 32'h0);
    n = 0;
    repeat (10) begin
      if (rv[1]) n++;
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", 1, 32'(n), 32'h0);
    chk("abort_ready_back", 1, 32'(crdy[1]), 32'h1);

    // Randomised traffic on both instances, checked by the model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 80; i++) begin
        logic [7:0] a;
        a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
        do_cmd(d, 2'($urandom_range(0, 3)), a, $urandom, int'($urandom_range(0, 3)),
               rdat, rerr, lat, nw, nr);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
